// File: rtl/core_wb_arbiter_pkg.sv
// rtl/core_wb_arbiter_pkg.sv - shared uarch types for the writeback path
// Writeback line, register index, retire mask and source enum used by the arbiter.
package core_wb_arbiter_pkg;
  localparam int NUM_WB_SRC = 3;
  localparam int REG_IDX_W  = 4;
  localparam int NUM_REGS   = 1 << REG_IDX_W;
  localparam int WB_VALUE_W = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  hword;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MUL = 2'd1,
    WB_MEM = 2'd2
  } wb_src_e;

  typedef struct packed {
    reg_idx_t              rd;
    logic [WB_VALUE_W-1:0] value;
    logic                  ready;
  } wb_line;

  function automatic wb_src_e wb_next_src(wb_src_e s);
    case (s)
      WB_ALU:  return WB_MUL;
      WB_MUL:  return WB_MEM;
      default: return WB_ALU;
    endcase
  endfunction

  function automatic hword onehot_rd(reg_idx_t rd);
    return hword'(1) << rd;
  endfunction
endpackage

// File: rtl/core_wb_fifo.sv
// rtl/core_wb_fifo.sv - per-source writeback FIFO
// A push into a full FIFO is dropped unless the head pops on the same edge.
module core_wb_fifo
  import core_wb_arbiter_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  reg_idx_t     i_push_rd,
  input  logic [W-1:0] i_push_value,
  input  logic         i_pop,
  output reg_idx_t     o_head_rd,
  output logic [W-1:0] o_head_value,
  output logic         o_empty,
  output logic         o_almost_full,
  output logic         o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  reg_idx_t      r_rd_mem  [DEPTH];
  logic [W-1:0]  r_val_mem [DEPTH];

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full        = (r_count == CNT_FULL);
  assign o_empty       = (r_count == '0);
  assign o_almost_full = (r_count >= CNT_AFULL);
  assign w_pop         = i_pop && !o_empty;
  assign w_push        = i_push && (!w_full || w_pop);
  assign o_drop        = i_push && w_full && !w_pop;
  assign o_head_rd     = r_rd_mem[r_rd_ptr];
  assign o_head_value  = r_val_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr]  <= i_push_rd;
      r_val_mem[r_wr_ptr] <= i_push_value;
    end
  end
endmodule

// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - round-robin writeback arbiter for alu/mul/mem results
// One register-file write per cycle; each source is buffered in its own FIFO.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  wb_line                i_alu_wb,
  input  wb_line                i_mul_wb,
  input  wb_line                i_mem_wb,
  output logic [NUM_WB_SRC-1:0] o_src_full,
  output logic                  o_rf_we,
  output reg_idx_t              o_rf_rd,
  output logic [W-1:0]          o_rf_value,
  output hword                  o_retire_mask,
  output logic                  o_overflow
);
  wb_line                w_src        [NUM_WB_SRC];
  reg_idx_t              w_head_rd    [NUM_WB_SRC];
  logic [W-1:0]          w_head_value [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0] w_empty;
  logic [NUM_WB_SRC-1:0] w_pop;
  logic [NUM_WB_SRC-1:0] w_drop;
  logic                  w_grant;
  wb_src_e               w_grant_src;
  wb_src_e               w_cand;

  wb_src_e  r_last;
  logic     r_rf_we;
  reg_idx_t r_rf_rd;
  logic [W-1:0] r_rf_value;
  hword     r_retire_mask;
  logic     r_overflow;

  assign w_src[WB_ALU] = i_alu_wb;
  assign w_src[WB_MUL] = i_mul_wb;
  assign w_src[WB_MEM] = i_mem_wb;

  for (genvar g = 0; g < NUM_WB_SRC; g++) begin : g_fifo
    assign w_pop[g] = w_grant && (w_grant_src == wb_src_e'(g));

    core_wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_push        (w_src[g].ready),
      .i_push_rd     (w_src[g].rd),
      .i_push_value  (w_src[g].value[W-1:0]),
      .i_pop         (w_pop[g]),
      .o_head_rd     (w_head_rd[g]),
      .o_head_value  (w_head_value[g]),
      .o_empty       (w_empty[g]),
      .o_almost_full (o_src_full[g]),
      .o_drop        (w_drop[g])
    );
  end

  // Search begins at the source after the last winner.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_src = r_last;
    w_cand      = r_last;
    for (int i = 0; i < NUM_WB_SRC; i++) begin
      w_cand = wb_next_src(w_cand);
      if (!w_grant && !w_empty[w_cand]) begin
        w_grant     = 1'b1;
        w_grant_src = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last        <= WB_MEM;
      r_rf_we       <= 1'b0;
      r_retire_mask <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_rf_we       <= w_grant;
      r_retire_mask <= w_grant ? onehot_rd(w_head_rd[w_grant_src]) : '0;
      if (w_grant) r_last <= w_grant_src;
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_rf_rd    <= w_head_rd[w_grant_src];
      r_rf_value <= w_head_value[w_grant_src];
    end
  end

  assign o_rf_we       = r_rf_we;
  assign o_rf_rd       = r_rf_rd;
  assign o_rf_value    = r_rf_value;
  assign o_retire_mask = r_retire_mask;
  assign o_overflow    = r_overflow;

  // Cross-source hazards to one rd must have been blocked by the scoreboard.
  a_distinct_head_rd: assert property (@(posedge clk) disable iff (!rst_n)
    !((!w_empty[0] && !w_empty[1] && w_head_rd[0] == w_head_rd[1]) ||
      (!w_empty[0] && !w_empty[2] && w_head_rd[0] == w_head_rd[2]) ||
      (!w_empty[1] && !w_empty[2] && w_head_rd[1] == w_head_rd[2])));
endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb/tb_core_wb_arbiter.sv - directed testbench for core_wb_arbiter
module tb_core_wb_arbiter;
  import core_wb_arbiter_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  wb_line       src_in [3];
  logic [2:0]   src_full;
  logic         rf_we;
  reg_idx_t     rf_rd;
  logic [W-1:0] rf_value;
  hword         retire_mask;
  logic         overflow;

  core_wb_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alu_wb      (src_in[0]),
    .i_mul_wb      (src_in[1]),
    .i_mem_wb      (src_in[2]),
    .o_src_full    (src_full),
    .o_rf_we       (rf_we),
    .o_rf_rd       (rf_rd),
    .o_rf_value    (rf_value),
    .o_retire_mask (retire_mask),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit               rst;
    bit [2:0]         push;
    logic [2:0][3:0]  rds;
    logic [2:0][15:0] vals;
    bit               we;
    bit               chkd;
    logic [3:0]       rd;
    logic [15:0]      val;
    logic [15:0]      mask;
  } vec_t;

  typedef struct { logic [3:0] rd; logic [15:0] val; } wr_t;
  typedef struct { int cyc; logic [2:0] val; } fchk_t;

  vec_t  vec [12];
  wr_t   exp_q[$];
  fchk_t fchk_q[$];
  logic [3:0]  rd_of [3];
  logic [15:0] base  [3];

  localparam int B_ALU [8] = '{0, 1, 2, 3, 4, 5, 7, 10};
  localparam int B_MUL [8] = '{0, 1, 2, 3, 4, 5, 8, 11};
  localparam int B_MEM [7] = '{0, 1, 2, 3, 4, 6, 9};
  localparam int D_SRC [13] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0, 0, 0};
  localparam int D_ALU [7] = '{0, 1, 2, 3, 4, 5, 7};

  function automatic vec_t mk(bit rst, bit [2:0] push, logic [11:0] rds, logic [47:0] vals,
                              bit we, bit chkd, logic [3:0] rd, logic [15:0] val, logic [15:0] mask);
    vec_t v;
    v.rst = rst; v.push = push; v.rds = rds; v.vals = vals;
    v.we = we; v.chkd = chkd; v.rd = rd; v.val = val; v.mask = mask;
    return v;
  endfunction

  task automatic idle_inputs();
    for (int s = 0; s < 3; s++) src_in[s] = '{rd: 4'd0, value: 16'd0, ready: 1'b0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset we", rf_we, 0);
    chk("reset mask", retire_mask, 0);
    chk("reset ovf", overflow, 0);
    chk("reset full", src_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_wr(input int s, input int seq);
    wr_t w;
    w.rd  = rd_of[s];
    w.val = 16'(base[s] + seq);
    exp_q.push_back(w);
  endtask

  task automatic run_stream(input string tag, input logic [31:0] pa, input logic [31:0] pm,
                            input logic [31:0] pe, input int ncyc, input int ovf_cyc);
    logic [31:0] pms [3];
    logic [15:0] m;
    bit exp_we;
    pms[0] = pa; pms[1] = pm; pms[2] = pe;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++)
        src_in[s] = '{rd: rd_of[s], value: 16'(base[s] + c), ready: pms[s][c]};
      #1;
      exp_we = (c >= 2) && (c < 2 + exp_q.size());
      chk($sformatf("%s we c%0d", tag, c), rf_we, exp_we);
      if (exp_we && rf_we) begin
        m = 16'h1 << exp_q[c-2].rd;
        chk($sformatf("%s rd c%0d", tag, c), rf_rd, exp_q[c-2].rd);
        chk($sformatf("%s value c%0d", tag, c), rf_value, exp_q[c-2].val);
        chk($sformatf("%s mask c%0d", tag, c), retire_mask, m);
      end else if (!exp_we) begin
        chk($sformatf("%s mask c%0d", tag, c), retire_mask, 0);
      end
      chk($sformatf("%s ovf c%0d", tag, c), overflow, (ovf_cyc >= 0 && c >= ovf_cyc));
      foreach (fchk_q[k])
        if (fchk_q[k].cyc == c) chk($sformatf("%s full c%0d", tag, c), src_full, fchk_q[k].val);
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k [3];
    idle_inputs();

    vec[0]  = mk(1, 3'b000, 12'h000, 48'h0, 0, 0, 0, 16'h0, 16'h0);
    vec[1]  = mk(0, 3'b001, 12'h003, {16'h0, 16'h0, 16'h1234}, 0, 0, 0, 16'h0, 16'h0);
    vec[2]  = mk(0, 3'b000, 12'h000, 48'h0, 0, 0, 0, 16'h0, 16'h0);
    vec[3]  = mk(0, 3'b000, 12'h000, 48'h0, 1, 1, 4'd3, 16'h1234, 16'h0008);
    vec[4]  = mk(0, 3'b000, 12'h000, 48'h0, 0, 1, 4'd3, 16'h1234, 16'h0000);
    vec[5]  = mk(1, 3'b000, 12'h000, 48'h0, 0, 0, 0, 16'h0, 16'h0);
    vec[6]  = mk(0, 3'b111, {4'd5, 4'd2, 4'd1}, {16'h0505, 16'h0202, 16'h0101}, 0, 0, 0, 16'h0, 16'h0);
    vec[7]  = mk(0, 3'b000, 12'h000, 48'h0, 0, 0, 0, 16'h0, 16'h0);
    vec[8]  = mk(0, 3'b000, 12'h000, 48'h0, 1, 1, 4'd1, 16'h0101, 16'h0002);
    vec[9]  = mk(0, 3'b000, 12'h000, 48'h0, 1, 1, 4'd2, 16'h0202, 16'h0004);
    vec[10] = mk(0, 3'b000, 12'h000, 48'h0, 1, 1, 4'd5, 16'h0505, 16'h0020);
    vec[11] = mk(0, 3'b000, 12'h000, 48'h0, 0, 1, 4'd5, 16'h0505, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst_n = !vec[i].rst;
      for (int s = 0; s < 3; s++)
        src_in[s] = '{rd: vec[i].rds[s], value: vec[i].vals[s], ready: vec[i].push[s]};
      #1;
      chk($sformatf("vec%0d we", i), rf_we, vec[i].we);
      chk($sformatf("vec%0d mask", i), retire_mask, vec[i].mask);
      chk($sformatf("vec%0d full", i), src_full, 0);
      chk($sformatf("vec%0d ovf", i), overflow, 0);
      if (vec[i].chkd) begin
        chk($sformatf("vec%0d rd", i), rf_rd, vec[i].rd);
        chk($sformatf("vec%0d value", i), rf_value, vec[i].val);
      end
    end
    idle_inputs();

    // ALU alone, back-to-back for 10 cycles
    rd_of = '{4'd6, 4'd7, 4'd11};
    base  = '{16'hA000, 16'hB000, 16'hC000};
    exp_q.delete(); fchk_q.delete();
    for (int i = 0; i < 10; i++) add_wr(0, i);
    for (int c = 0; c < 14; c++) fchk_q.push_back('{c, 3'b000});
    do_reset();
    run_stream("alu_stream", 32'h3FF, 32'h0, 32'h0, 14, -1);

    // All three streaming for 12 cycles, then drain
    rd_of = '{4'd1, 4'd2, 4'd3};
    base  = '{16'h1000, 16'h2000, 16'h3000};
    exp_q.delete(); fchk_q.delete();
    k = '{0, 0, 0};
    for (int g = 1; g <= 23; g++) begin
      case ((g - 1) % 3)
        0:       begin add_wr(0, B_ALU[k[0]]); k[0]++; end
        1:       begin add_wr(1, B_MUL[k[1]]); k[1]++; end
        default: begin add_wr(2, B_MEM[k[2]]); k[2]++; end
      endcase
    end
    fchk_q.push_back('{0, 3'b000});
    fchk_q.push_back('{2, 3'b000});
    fchk_q.push_back('{3, 3'b100});
    fchk_q.push_back('{4, 3'b111});
    fchk_q.push_back('{25, 3'b000});
    do_reset();
    run_stream("all_stream", 32'hFFF, 32'hFFF, 32'hFFF, 27, 6);

    // Reset with two entries buffered while a write is on the outputs
    do_reset();
    @(negedge clk);
    src_in[0] = '{rd: 4'd4, value: 16'h4444, ready: 1'b1};
    src_in[1] = '{rd: 4'd7, value: 16'h7777, ready: 1'b1};
    @(negedge clk);
    src_in[0] = '{rd: 4'd5, value: 16'h5555, ready: 1'b1};
    src_in[1] = '{rd: 4'd0, value: 16'h0000, ready: 1'b0};
    @(negedge clk);
    idle_inputs();
    #1;
    chk("midrst pre we", rf_we, 1);
    chk("midrst pre rd", rf_rd, 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst we", rf_we, 0);
    chk("midrst mask", retire_mask, 0);
    chk("midrst full", src_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst we c%0d", c), rf_we, 0);
      chk($sformatf("postrst mask c%0d", c), retire_mask, 0);
    end

    // ALU FIFO full with a grant and a push on the same edge
    rd_of = '{4'd8, 4'd9, 4'd10};
    base  = '{16'h8000, 16'h9000, 16'hA000};
    exp_q.delete(); fchk_q.delete();
    k = '{0, 0, 0};
    for (int g = 0; g < 13; g++) begin
      if (D_SRC[g] == 0) begin add_wr(0, D_ALU[k[0]]); k[0]++; end
      else begin add_wr(D_SRC[g], k[D_SRC[g]]); k[D_SRC[g]]++; end
    end
    fchk_q.push_back('{3, 3'b100});
    fchk_q.push_back('{4, 3'b001});
    fchk_q.push_back('{6, 3'b001});
    fchk_q.push_back('{8, 3'b001});
    fchk_q.push_back('{11, 3'b001});
    fchk_q.push_back('{12, 3'b000});
    do_reset();
    run_stream("full_popush", 32'hBF, 32'h7, 32'h7, 17, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_wb_arbiter.md
CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 Parameter W, default 16: register value width in bits.
REQ-002 Parameter DEPTH, default 4: entries per source FIFO; power of two, >= 2.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 alu_wb  in  wb_line  ALU result (rd, value, ready).
REQ-006 mul_wb  in  wb_line  multiplier result.
REQ-007 mem_wb  in  wb_line  load-unit result.
REQ-008 src_full  out  3  per source {mem,mul,alu}: FIFO count >= DEPTH-1; issue stage stops issuing to that unit.
REQ-009 rf_we  out  1  register-file write enable.
REQ-010 rf_rd  out  4  destination register.
REQ-011 rf_value  out  W  write data.
REQ-012 retire_mask  out  hword  one-hot of rf_rd when rf_we, else zero; clears RAW scoreboard bits.
REQ-013 overflow  out  1  sticky error: a push was attempted into a full FIFO.

Function
REQ-014 Each source has a private FIFO; ready=1 sampled at a posedge pushes {rd,value}.
REQ-015 Push into a full FIFO: entry dropped, FIFO unchanged, overflow set to 1 at that edge and held until reset.
REQ-016 Arbitration is combinational over non-empty FIFO heads, one grant per cycle.
REQ-017 Round-robin order alu->mul->mem->alu; the search starts at the source after the last granted one; pointer updates only on a grant.
REQ-018 Granted head pops at the same posedge that registers rf_we=1, rf_rd, rf_value, retire_mask.
REQ-019 No grant in a cycle: rf_we=0 and retire_mask=0 at the next edge; rf_rd/rf_value hold previous values.
REQ-020 Latency: ready high in cycle C, empty FIFOs, no contention -> rf_we high in cycle C+2.
REQ-021 Simultaneous push and pop on the same FIFO is legal when full or empty: full+pop+push keeps count at DEPTH with no overflow; empty+push with no pop is never granted that cycle.
REQ-022 FIFO pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-023 Per-source ordering is preserved; cross-source ordering to the same rd is not guaranteed (the scoreboard prevents it); a simulation assertion flags two valid heads with equal rd.
REQ-024 Sustained throughput 1 write/cycle; with all three sources streaming, each receives exactly 1 grant per 3 cycles.

Reset
REQ-025 On rst_n low, immediately: all FIFOs empty, rr pointer = mem (so alu wins first), rf_we=0, retire_mask=0, overflow=0, src_full=0; rf_rd and rf_value are undefined (x).
REQ-026 Reset mid-stream discards all buffered entries; nothing written after release until a new push.

Structure
REQ-027 wb_line, hword, register-index width, NUM_WB_SRC=3 and the source-index enum (WB_ALU, WB_MUL, WB_MEM) live in the shared uarch package.
REQ-028 One sub-module core_wb_fifo (parameters W, DEPTH; push, pop, head, empty, almost_full), instantiated three times.

Verification
REQ-029 Single ALU push rd=3, value=0x1234 in cycle 0 -> rf_we=1, rf_rd=3, rf_value=0x1234, retire_mask=0x0008 in cycle 2 only.
REQ-030 alu, mul, mem push in the same cycle (rd=1, 2, 5) after reset -> writes in order rd 1, 2, 5 on three consecutive cycles.
REQ-031 ALU pushes every cycle for 10 cycles, others idle -> 10 back-to-back writes, order preserved, src_full[0] never set, overflow=0.
REQ-032 All sources stream 12 cycles -> grants rotate alu, mul, mem; src_full asserts at count 3; a 5th push into a full DEPTH=4 FIFO sets overflow and is not written.
REQ-033 Assert rst_n low with 2 entries buffered -> rf_we and retire_mask drop immediately; no writes after release.
REQ-034 Full FIFO with simultaneous grant and push -> count stays 4, overflow stays 0, data order intact.
